hack_cpu_mc: RTL and testbench

HACK_CPU_MC -- requirements
Module: hack_cpu_mc

---
 rtl/hack_cpu_mc.sv | 130 +++++++++++++
 tb/tb_hack_cpu_mc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH -> EXEC -> (MEM) -> FETCH, with
// request/ack handshakes for instruction and data memory.
module hack_cpu_mc #(
  parameter int DW = 16,
  parameter int AW = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   instr,
  input  logic          instr_valid,
  output logic          fetch_req,
  output logic [AW-1:0] pc,
  input  logic [DW-1:0] inM,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          writeM,
  output logic [DW-1:0] outM,
  output logic [AW-1:0] addressM,
  output logic          halted
);

  typedef enum logic [1:0] {
    FETCH, EXEC, MEM, HALT
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic          preva_q, preva_d;

  logic [DW-1:0] x0, x1, y0, y1, f_r, res;
  logic [AW-1:0] pc_inc;
  logic          ng, zr, taken, is_halt, commit;

  assign x0  = ir_q[11] ? '0 : d_q;
  assign x1  = ir_q[10] ? ~x0 : x0;
  assign y0  = ir_q[9] ? '0 : (ir_q[12] ? inM : a_q);
  assign y1  = ir_q[8] ? ~y0 : y0;
  assign f_r = ir_q[7] ? (x1 + y1) : (x1 & y1);
  assign res = ir_q[6] ? ~f_r : f_r;

  assign ng     = res[DW-1];
  assign zr     = (res == '0);
  assign taken  = (ir_q[2] & ng) | (ir_q[1] & zr)
                | (ir_q[0] & ~ng & ~zr);
  assign pc_inc = pc_q + AW'(1);

  // "@n / 0;JMP" sitting at n+1 is the canonical end-of-program loop
  assign is_halt = (ir_q[2:0] == 3'b111)
                && (ir_q[5:3] == 3'b000)
                && preva_q
                && (a_q[AW-1:0] == pc_q - AW'(1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    preva_d = preva_q;
    commit  = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!ir_q[15]) begin
          a_d     = {{(DW-15){1'b0}}, ir_q[14:0]};
          pc_d    = pc_inc;
          preva_d = 1'b1;
          state_d = FETCH;
        end else if (ir_q[12] || ir_q[3]) begin
          state_d = MEM;
        end else begin
          commit = 1'b1;
        end
      end
      MEM: begin
        if (mem_ack) commit = 1'b1;
      end
      HALT: begin
        state_d = HALT;
      end
    endcase
    if (commit) begin
      preva_d = 1'b0;
      if (is_halt) begin
        state_d = HALT;
      end else begin
        state_d = FETCH;
        if (ir_q[5]) a_d = res;
        if (ir_q[4]) d_d = res;
        pc_d = taken ? a_q[AW-1:0] : pc_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      preva_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      preva_q <= preva_d;
    end
  end

  // Gated by reset so the handshakes drop the instant reset rises
  assign fetch_req = (state_q == FETCH) & ~reset;
  assign mem_req   = (state_q == MEM) & ~reset;
  assign writeM    = (state_q == MEM) & ir_q[3] & ~reset;
  assign halted    = (state_q == HALT) & ~reset;
  assign pc        = pc_q;
  assign addressM  = a_q[AW-1:0];
  assign outM      = res;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Scoreboard bench for hack_cpu_mc: driver pushes expected fetch pcs
// and memory transactions, a negedge monitor pops and compares.
module tb_hack_cpu_mc;

  logic        clock;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        fetch_req;
  logic [14:0] pc;
  logic [15:0] inM;
  logic        mem_req;
  logic        mem_ack;
  logic        writeM;
  logic [15:0] outM;
  logic [14:0] addressM;
  logic        halted;

  hack_cpu_mc #(.DW(16), .AW(15)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .inM         (inM),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .writeM      (writeM),
    .outM        (outM),
    .addressM    (addressM),
    .halted      (halted)
  );

  typedef struct {
    logic [14:0] addr;
    logic        we;
    logic [15:0] data;
  } mev_t;

  int          checks = 0;
  int          failures = 0;
  logic [14:0] pc_q_exp[$];
  mev_t        mem_q_exp[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    mev_t m;
    logic [14:0] p;
    forever begin
      @(negedge clock);
      if (fetch_req && instr_valid) begin
        if (pc_q_exp.size() == 0) begin
          chk("unexpected_fetch", 32'(pc), 32'h7fff_ffff);
        end else begin
          p = pc_q_exp.pop_front();
          chk("fetch_pc", 32'(pc), 32'(p));
        end
      end
      if (mem_req && mem_ack) begin
        if (mem_q_exp.size() == 0) begin
          chk("unexpected_mem", 32'(addressM), 32'h7fff_ffff);
        end else begin
          m = mem_q_exp.pop_front();
          chk("mem_addr", 32'(addressM), 32'(m.addr));
          chk("mem_we", 32'(writeM), 32'(m.we));
          if (m.we) chk("mem_outM", 32'(outM), 32'(m.data));
        end
      end
      if (writeM) chk("writeM_only_in_mem", 32'(mem_req), 32'd1);
    end
  end

  task automatic push_mem(input logic [14:0] a, input logic we,
                          input logic [15:0] d);
    mev_t m;
    m.addr = a;
    m.we   = we;
    m.data = d;
    mem_q_exp.push_back(m);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_fetch_req", 32'(fetch_req), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_writeM", 32'(writeM), 0);
    chk("rst_halted", 32'(halted), 0);
    @(posedge clock);
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_A", 32'(dut.a_q), 0);
    chk("rst_D", 32'(dut.d_q), 0);
    reset = 1'b0;
  endtask

  task automatic exec(input logic [14:0] pce, input logic [15:0] ins,
                      input logic [15:0] m, input int dly,
                      output int memcyc);
    int n;
    memcyc = 0;
    n = 0;
    while (!fetch_req && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!fetch_req) begin
      chk("fetch_timeout", 32'(fetch_req), 1);
      return;
    end
    pc_q_exp.push_back(pce);
    instr = ins;
    inM = m;
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    @(posedge clock);
    #1;
    if (mem_req) begin
      memcyc = 1;
      for (int i = 0; i < dly; i++) begin
        @(posedge clock);
        #1;
        if (mem_req) memcyc++;
      end
      mem_ack = 1'b1;
      @(posedge clock);
      #1 mem_ack = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mc;
    instr = '0;
    instr_valid = 1'b0;
    inM = '0;
    mem_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    do_reset();

    exec(0, 16'h0005, 0, 0, mc);
    chk("a_inst_A", 32'(dut.a_q), 5);
    chk("a_inst_pc", 32'(pc), 1);
    chk("a_inst_fetch_req", 32'(fetch_req), 1);

    do_reset();
    exec(0, 16'h0007, 0, 0, mc);
    exec(1, 16'hEC10, 0, 0, mc);
    exec(2, 16'h0064, 0, 0, mc);
    push_mem(15'd100, 1'b1, 16'd7);
    exec(3, 16'hE308, 0, 3, mc);
    chk("st_mem_cycles", 32'(mc), 4);
    chk("st_pc", 32'(pc), 4);
    chk("st_D", 32'(dut.d_q), 7);
    chk("st_writeM_after", 32'(writeM), 0);

    push_mem(15'd100, 1'b1, 16'd42);
    exec(4, 16'hFDC8, 16'd41, 0, mc);
    chk("rmw_mem_cycles", 32'(mc), 1);
    chk("rmw_D", 32'(dut.d_q), 7);
    chk("rmw_pc", 32'(pc), 5);

    push_mem(15'd100, 1'b0, 16'd41);
    exec(5, 16'hFC10, 16'd41, 1, mc);
    chk("ld_D", 32'(dut.d_q), 41);

    exec(6, 16'hEA90, 0, 0, mc);
    exec(7, 16'h000A, 0, 0, mc);
    exec(8, 16'hE302, 0, 0, mc);
    chk("jeq_pc", 32'(pc), 10);
    exec(10, 16'hE301, 0, 0, mc);
    chk("jgt_pc", 32'(pc), 11);
    exec(11, 16'hEE90, 0, 0, mc);
    chk("neg1_D", 32'(dut.d_q), 32'hFFFF);
    exec(12, 16'hE304, 0, 0, mc);
    chk("jlt_pc", 32'(pc), 10);

    do_reset();
    exec(0, 16'h0005, 0, 0, mc);
    exec(1, 16'hEA87, 0, 0, mc);
    chk("jmp_pc", 32'(pc), 5);
    exec(5, 16'h0006, 0, 0, mc);
    exec(6, 16'hEC10, 0, 0, mc);
    exec(7, 16'hEA87, 0, 0, mc);
    chk("nohalt_halted", 32'(halted), 0);
    chk("nohalt_pc", 32'(pc), 6);
    exec(6, 16'h0006, 0, 0, mc);
    exec(7, 16'hEA87, 0, 0, mc);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_pc", 32'(pc), 7);
    chk("halt_fetch_req", 32'(fetch_req), 0);
    repeat (4) @(posedge clock);
    #1;
    chk("halt_stays", 32'(halted), 1);
    chk("halt_no_mem", 32'(mem_req), 0);

    do_reset();
    exec(0, 16'h0003, 0, 0, mc);
    exec(1, 16'hEC10, 0, 0, mc);
    exec(2, 16'h0064, 0, 0, mc);
    pc_q_exp.push_back(15'd3);
    instr = 16'hE308;
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_in_mem", 32'(mem_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_writeM", 32'(writeM), 0);
    @(posedge clock);
    #1;
    chk("abort_pc", 32'(pc), 0);
    chk("abort_A", 32'(dut.a_q), 0);
    chk("abort_D", 32'(dut.d_q), 0);
    reset = 1'b0;

    exec(0, 16'h7FFF, 0, 0, mc);
    exec(1, 16'hEA87, 0, 0, mc);
    chk("top_pc", 32'(pc), 32'h7FFF);
    exec(15'h7FFF, 16'hEC10, 0, 0, mc);
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_D", 32'(dut.d_q), 32'h7FFF);

    repeat (2) @(posedge clock);
    chk("fetch_q_empty", 32'(pc_q_exp.size()), 0);
    chk("mem_q_empty", 32'(mem_q_exp.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
